wr_chunk_packetizer: RTL and testbench
======================================

# wr_chunk_packetizer

Parametrised stream-to-host write packetizer for the vFPGA user logic. Forwards a host-bound AXI4S stream to the downstream data FIFO and splits each packet into chunks of at most `CHUNK_BEATS` beats. For every chunk it issues one write descriptor on the bypass write-request channel, carrying a byte-accurate length from `tkeep` and a byte-accurate address advance. It also tracks outstanding writes against the write-done channel and caps them at `MAX_OUTSTANDING`.

## Interface
- `DATA_BITS`, 512: stream data width; `KEEP_BITS = DATA_BITS/8`.
- `VADDR_BITS`, 48: virtual address width.
- `LEN_BITS`, 28: descriptor length width (bytes).
- `PID_BITS`, 6: process id width.
- `CHUNK_BEATS`, 64: maximum beats per descriptor (PMTU/beat bytes), ≥1.
- `MAX_OUTSTANDING`, 8: maximum issued-but-not-done descriptors, ≥1; counter width `$clog2(MAX_OUTSTANDING+1)`.
- `aclk`  in  1  clock. One clock domain.
- `areset`  in  1  reset, asynchronous and active-high.
- `s_axis_tvalid/tready/tdata/tkeep/tlast`  in/out/in/in/in  1/1/DATA_BITS/KEEP_BITS/1  packet stream from the pipeline.
- `m_axis_tvalid/tready/tdata/tkeep/tlast`  out/in/out/out/out  same widths  stream to the sender data FIFO.
- `wr_req_valid/ready`  out/in  1/1  bypass write-request handshake.
- `wr_req_vaddr`  out  VADDR_BITS  chunk start address.
- `wr_req_len`  out  LEN_BITS  chunk length in bytes.
- `wr_req_ctl`  out  1  1 = final chunk of the packet.
- `wr_req_pid`  out  PID_BITS  process id.
- `wr_done_valid/ready`  in/out  1/1  write completion; `wr_done_ready` is tied 1.
- `cfg_vaddr`  in  VADDR_BITS  base address of the destination buffer, from the control slave.
- `cfg_pid`  in  PID_BITS  process id, from the control slave.
- `stat_outstanding`  out  counter width  current outstanding descriptors.
- `stat_pkts`  out  32  packets whose final descriptor has been issued.
- `stat_err`  out  1  sticky flag: a `wr_done` arrived with zero outstanding.

## Operation
- States: `ST_FILL`, `ST_SEND`, `ST_SEND_LAST`. Reset state is `ST_FILL`.
- `ST_FILL`:
  - `m_axis_t{data,keep,last} = s_axis_*`, `m_axis_tvalid = s_axis_tvalid`, `s_axis_tready = m_axis_tready`. The path is combinational with no added latency.
  - On each beat handshake: `beat_cnt += 1` and `byte_cnt += popcount(tkeep)`.
  - On the first beat of a packet (offset == 0 and `beat_cnt == 0`), latch `cfg_vaddr` and `cfg_pid` into `base_q` and `pid_q`. Config changes mid-packet have no effect.
- Chunk close, evaluated on the handshaked beat:
  - `tlast` → `ST_SEND_LAST`. This takes priority when `tlast` coincides with `beat_cnt == CHUNK_BEATS-1`: the result is one descriptor with ctl=1.
  - Else `beat_cnt == CHUNK_BEATS-1` → `ST_SEND`.
- `ST_SEND` / `ST_SEND_LAST`:
  - `s_axis_tready = 0` and `m_axis_tvalid = 0`.
  - `wr_req_valid = (outstanding < MAX_OUTSTANDING)`.
  - `vaddr = base_q + offset_q`, `len = byte_cnt`, `ctl = (state == ST_SEND_LAST)`, `pid = pid_q`.
  - Fields stay stable while valid is high.
- On request handshake:
  - `beat_cnt` and `byte_cnt` reset to 0.
  - `ST_SEND`: `offset_q += byte_cnt`. Width is VADDR_BITS and wraps modulo 2^VADDR_BITS.
  - `ST_SEND_LAST`: `offset_q` resets to 0 and `stat_pkts` increments (32-bit wrap).
  - Next state is `ST_FILL`.
- Outstanding counter: increments on request handshake, decrements on `wr_done` handshake. Simultaneous increment and decrement leaves it unchanged.
- A `wr_done` with outstanding == 0 leaves the counter at 0 and sets `stat_err`. The flag clears only on reset.
- `tkeep` is counted as given. Non-final beats are expected to be full; this is not checked.

## Timing
- All outputs are reset (asynchronously):
  - `wr_req_valid = 0`, `wr_req_*` fields = 0.
  - `stat_outstanding = 0`, `stat_pkts = 0`, `stat_err = 0`.
  - `m_axis_tvalid = 0`.
  - `s_axis_tready = 0` while `areset` is asserted.
  - All counters and offset = 0.
- `wr_req_valid` rises the cycle after the chunk-closing beat, provided outstanding < max.
- Input back-pressure is one or more cycles per chunk: at least one idle cycle on `s_axis` between chunks.
- Outstanding is full: `wr_req_valid` is held 0 and the state is held until a `wr_done` arrives. Valid rises the cycle after the decrement.
- Reset mid-chunk discards the partial chunk. No descriptor is issued for it.

## Test plan
- `CHUNK_BEATS=4`, `cfg_vaddr=0x1000`, 10-beat full-keep packet → descriptors (0x1000,256,ctl0), (0x1100,256,ctl0), (0x1200,128,ctl1); `stat_pkts=1`; all 10 beats appear on `m_axis` unchanged.
- 3-beat packet, last `tkeep=0xFF` → a single descriptor with len=136, ctl=1. The next packet starts at offset 0 with a newly latched `cfg_vaddr`.
- 4-beat packet with `CHUNK_BEATS=4` (`tlast` on the 4th beat) → exactly one descriptor, len=256, ctl=1.
- `MAX_OUTSTANDING=2`, no `wr_done`, 12-beat packet → two descriptors issued, third valid held 0 with `s_axis_tready=0`. One `wr_done` → third descriptor issued next cycle.
- Simultaneous request handshake and `wr_done` at outstanding=1 → stays 1. `wr_done` at outstanding=0 → `stat_err=1`, counter stays 0.
- `areset` pulse after 2 beats of a chunk → no descriptor issued, all outputs at reset values. A following 1-beat packet gives (cfg_vaddr, 64, ctl1).

Source files
------------

// File: rtl/wr_chunk_packetizer.sv
// wr_chunk_packetizer: forwards a host-bound stream and cuts each packet
// into chunks, issuing one byte-accurate write descriptor per chunk.
module wr_chunk_packetizer #(
  parameter int DATA_BITS       = 512,
  parameter int VADDR_BITS      = 48,
  parameter int LEN_BITS        = 28,
  parameter int PID_BITS        = 6,
  parameter int CHUNK_BEATS     = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int KEEP_BITS      = DATA_BITS / 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_BITS-1:0]  s_axis_tdata,
  input  logic [KEEP_BITS-1:0]  s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_BITS-1:0]  m_axis_tdata,
  output logic [KEEP_BITS-1:0]  m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [VADDR_BITS-1:0] wr_req_vaddr,
  output logic [LEN_BITS-1:0]   wr_req_len,
  output logic                  wr_req_ctl,
  output logic [PID_BITS-1:0]   wr_req_pid,
  input  logic                  wr_done_valid,
  output logic                  wr_done_ready,
  input  logic [VADDR_BITS-1:0] cfg_vaddr,
  input  logic [PID_BITS-1:0]   cfg_pid,
  output logic [CW-1:0]         stat_outstanding,
  output logic [31:0]           stat_pkts,
  output logic                  stat_err
);

  localparam int BW = $clog2(CHUNK_BEATS + 1);
  localparam int PW = $clog2(KEEP_BITS + 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_SEND,
    ST_SEND_LAST
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [BW-1:0]         beat_q;
  logic [LEN_BITS-1:0]   byte_q;
  logic [VADDR_BITS-1:0] offset_q;
  logic [VADDR_BITS-1:0] base_q;
  logic [PID_BITS-1:0]   pid_q;
  logic [CW-1:0]         out_q;
  logic [31:0]           pkts_q;
  logic                  err_q;
  logic [PW-1:0]         pc;
  logic                  can_issue;
  logic                  fill_hs;
  logic                  req_hs;
  logic                  last_beat;

  assign can_issue = out_q < CW'(MAX_OUTSTANDING);
  assign last_beat = beat_q == BW'(CHUNK_BEATS - 1);

  // Handshakes derived from state, not from the outputs, to avoid loops.
  assign fill_hs = (state_q == ST_FILL) & ~areset
                 & s_axis_tvalid & m_axis_tready;
  assign req_hs  = (state_q != ST_FILL) & can_issue
                 & wr_req_ready;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;

  assign wr_req_vaddr  = base_q + offset_q;
  assign wr_req_len    = byte_q;
  assign wr_req_ctl    = state_q == ST_SEND_LAST;
  assign wr_req_pid    = pid_q;
  assign wr_done_ready = 1'b1;

  assign stat_outstanding = out_q;
  assign stat_pkts        = pkts_q;
  assign stat_err         = err_q;

  // Count valid bytes of the current beat.
  always_comb begin
    pc = '0;
    for (int i = 0; i < KEEP_BITS; i++) begin
      pc = pc + PW'(s_axis_tkeep[i]);
    end
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; tlast wins over a full chunk.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    wr_req_valid  = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        s_axis_tready = m_axis_tready & ~areset;
        m_axis_tvalid = s_axis_tvalid & ~areset;
        if (fill_hs) begin
          if (s_axis_tlast)   state_d = ST_SEND_LAST;
          else if (last_beat) state_d = ST_SEND;
        end
      end
      ST_SEND, ST_SEND_LAST: begin
        wr_req_valid = can_issue;
        if (req_hs) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Chunk accumulation, packet base latch and address advance.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_q   <= '0;
      byte_q   <= '0;
      offset_q <= '0;
      base_q   <= '0;
      pid_q    <= '0;
      pkts_q   <= '0;
    end else begin
      if (fill_hs) begin
        beat_q <= beat_q + BW'(1);
        byte_q <= byte_q + LEN_BITS'(pc);
        if (offset_q == '0 && beat_q == '0) begin
          base_q <= cfg_vaddr;
          pid_q  <= cfg_pid;
        end
      end
      if (req_hs) begin
        beat_q <= '0;
        byte_q <= '0;
        if (state_q == ST_SEND_LAST) begin
          offset_q <= '0;
          pkts_q   <= pkts_q + 32'd1;
        end else begin
          offset_q <= offset_q + VADDR_BITS'(byte_q);
        end
      end
    end
  end

  // Outstanding descriptors; a completion with none in flight is sticky.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else if (req_hs && !wr_done_valid) begin
      out_q <= out_q + CW'(1);
    end else if (!req_hs && wr_done_valid) begin
      if (out_q == '0) err_q <= 1'b1;
      else             out_q <= out_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_wr_chunk_packetizer.sv
// tb_wr_chunk_packetizer: directed vectors for chunking, outstanding cap,
// completion accounting and mid-chunk reset.
module tb_wr_chunk_packetizer;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int VA = 48;
  localparam int LB = 28;
  localparam int PB = 6;
  localparam int CB = 4;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          wr_req_valid;
  logic          wr_req_ready = 1'b1;
  logic [VA-1:0] wr_req_vaddr;
  logic [LB-1:0] wr_req_len;
  logic          wr_req_ctl;
  logic [PB-1:0] wr_req_pid;
  logic          wr_done_valid = 1'b0;
  logic          wr_done_ready;
  logic [VA-1:0] cfg_vaddr = '0;
  logic [PB-1:0] cfg_pid = '0;
  logic [CW-1:0] stat_outstanding;
  logic [31:0]   stat_pkts;
  logic          stat_err;

  int n_vec = 0;
  int n_err = 0;
  bit auto_done = 1'b0;

  logic [DW-1:0] exp_d[$];
  logic [KW-1:0] exp_k[$];
  logic          exp_l[$];
  logic [DW-1:0] got_d[$];
  logic [KW-1:0] got_k[$];
  logic          got_l[$];
  logic [VA-1:0] dq_a[$];
  logic [LB-1:0] dq_n[$];
  logic          dq_c[$];
  logic [PB-1:0] dq_p[$];

  wr_chunk_packetizer #(
    .DATA_BITS(DW), .VADDR_BITS(VA), .LEN_BITS(LB),
    .PID_BITS(PB), .CHUNK_BEATS(CB), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
    .wr_req_vaddr(wr_req_vaddr), .wr_req_len(wr_req_len),
    .wr_req_ctl(wr_req_ctl), .wr_req_pid(wr_req_pid),
    .wr_done_valid(wr_done_valid), .wr_done_ready(wr_done_ready),
    .cfg_vaddr(cfg_vaddr), .cfg_pid(cfg_pid),
    .stat_outstanding(stat_outstanding), .stat_pkts(stat_pkts),
    .stat_err(stat_err)
  );

  always #5 aclk = ~aclk;

  // Monitor both output channels mid-cycle.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_k.push_back(m_axis_tkeep);
      got_l.push_back(m_axis_tlast);
    end
    if (!areset && wr_req_valid && wr_req_ready) begin
      dq_a.push_back(wr_req_vaddr);
      dq_n.push_back(wr_req_len);
      dq_c.push_back(wr_req_ctl);
      dq_p.push_back(wr_req_pid);
    end
  end

  // Optional responder: completes each descriptor one cycle later.
  initial begin
    logic pend;
    forever begin
      @(negedge aclk);
      pend = wr_req_valid && wr_req_ready;
      @(posedge aclk);
      #1;
      if (auto_done) wr_done_valid = pend;
    end
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beats(input int n, input bit last,
                            input logic [KW-1:0] lkeep,
                            input int seed);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      bit hs;
      int budget;
      for (int w = 0; w < DW / 32; w++) d[w*32+:32] = 32'(seed + i);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = last && (i == n - 1);
      s_axis_tkeep  = (last && i == n - 1) ? lkeep : '1;
      hs = 1'b0;
      budget = 0;
      while (!hs && budget < 200) begin
        @(negedge aclk);
        hs = s_axis_tvalid && s_axis_tready;
        tick();
        budget++;
      end
      if (!hs) chk("beat_timeout", 0, 1);
      exp_d.push_back(d);
      exp_k.push_back(s_axis_tkeep);
      exp_l.push_back(s_axis_tlast);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_desc(input int n);
    int budget = 0;
    while (dq_a.size() < n && budget < 200) begin
      tick();
      budget++;
    end
    if (dq_a.size() < n) chk("desc_timeout", dq_a.size(), n);
  endtask

  task automatic chk_desc(input int idx, input logic [VA-1:0] a,
                          input logic [LB-1:0] n, input logic c,
                          input logic [PB-1:0] p);
    if (idx >= dq_a.size()) begin
      chk("desc_missing", dq_a.size(), idx + 1);
    end else begin
      chk($sformatf("d%0d_vaddr", idx), dq_a[idx], a);
      chk($sformatf("d%0d_len", idx), dq_n[idx], n);
      chk($sformatf("d%0d_ctl", idx), dq_c[idx], c);
      chk($sformatf("d%0d_pid", idx), dq_p[idx], p);
    end
  endtask

  task automatic pulse_done();
    wr_done_valid = 1'b1;
    tick();
    wr_done_valid = 1'b0;
  endtask

  initial begin
    int base;
    // Reset state with the stream offering a beat.
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_req_valid", wr_req_valid, 0);
    chk("rst_req_vaddr", wr_req_vaddr, 0);
    chk("rst_req_len", wr_req_len, 0);
    chk("rst_req_ctl", wr_req_ctl, 0);
    chk("rst_req_pid", wr_req_pid, 0);
    chk("rst_outst", stat_outstanding, 0);
    chk("rst_pkts", stat_pkts, 0);
    chk("rst_err", stat_err, 0);
    chk("rst_done_rdy", wr_done_ready, 1);
    s_axis_tvalid = 1'b0;
    tick();
    areset = 1'b0;
    tick();

    // 10-beat packet; mid-packet cfg change must be ignored.
    auto_done = 1'b1;
    cfg_vaddr = 48'h1000;
    cfg_pid   = 6'd5;
    send_beats(2, 1'b0, '1, 32'h100);
    cfg_vaddr = 48'h9000;
    cfg_pid   = 6'd9;
    send_beats(8, 1'b1, '1, 32'h102);
    wait_desc(3);
    repeat (4) tick();
    chk("t1_ndesc", dq_a.size(), 3);
    chk_desc(0, 48'h1000, 256, 1'b0, 6'd5);
    chk_desc(1, 48'h1100, 256, 1'b0, 6'd5);
    chk_desc(2, 48'h1200, 128, 1'b1, 6'd5);
    chk("t1_pkts", stat_pkts, 1);
    chk("t1_outst", stat_outstanding, 0);

    // 3 beats, 8-byte tail; new base latched at offset 0.
    cfg_vaddr = 48'h2000;
    cfg_pid   = 6'd7;
    send_beats(3, 1'b1, 64'hFF, 32'h200);
    wait_desc(4);
    repeat (4) tick();
    chk("t2_ndesc", dq_a.size(), 4);
    chk_desc(3, 48'h2000, 136, 1'b1, 6'd7);
    chk("t2_pkts", stat_pkts, 2);

    // tlast on the chunk boundary: one descriptor only.
    cfg_vaddr = 48'h3000;
    send_beats(4, 1'b1, '1, 32'h300);
    wait_desc(5);
    repeat (6) tick();
    chk("t3_ndesc", dq_a.size(), 5);
    chk_desc(4, 48'h3000, 256, 1'b1, 6'd7);
    chk("t3_pkts", stat_pkts, 3);
    chk("t3_outst", stat_outstanding, 0);

    // Outstanding cap of 2 with no completions.
    auto_done = 1'b0;
    tick();
    cfg_vaddr = 48'h4000;
    cfg_pid   = 6'd2;
    base = dq_a.size();
    fork
      send_beats(12, 1'b1, '1, 32'h400);
      begin
        wait_desc(base + 2);
        repeat (10) tick();
        @(negedge aclk);
        chk("t4_ndesc_held", dq_a.size(), base + 2);
        chk("t4_req_held", wr_req_valid, 0);
        chk("t4_tready_held", s_axis_tready, 0);
        chk("t4_outst_full", stat_outstanding, 2);
        tick();
        pulse_done();
        @(negedge aclk);
        chk("t4_req_after_done", wr_req_valid, 1);
        tick();
      end
    join
    wait_desc(base + 3);
    repeat (2) tick();
    chk("t4_ndesc", dq_a.size(), base + 3);
    chk_desc(base, 48'h4000, 256, 1'b0, 6'd2);
    chk_desc(base + 1, 48'h4100, 256, 1'b0, 6'd2);
    chk_desc(base + 2, 48'h4200, 256, 1'b1, 6'd2);
    chk("t4_outst", stat_outstanding, 2);

    // Simultaneous issue and completion at outstanding 1.
    pulse_done();
    @(negedge aclk);
    chk("t5_outst_1", stat_outstanding, 1);
    tick();
    wr_req_ready = 1'b0;
    cfg_vaddr = 48'h5000;
    send_beats(1, 1'b1, '1, 32'h500);
    begin
      int budget = 0;
      while (!wr_req_valid && budget < 50) begin
        tick();
        budget++;
      end
      chk("t5_req_up", wr_req_valid, 1);
    end
    wr_req_ready  = 1'b1;
    wr_done_valid = 1'b1;
    tick();
    wr_done_valid = 1'b0;
    @(negedge aclk);
    chk("t5_outst_same", stat_outstanding, 1);
    chk_desc(base + 3, 48'h5000, 64, 1'b1, 6'd2);
    tick();
    pulse_done();
    @(negedge aclk);
    chk("t5_outst_0", stat_outstanding, 0);
    chk("t5_err_clear", stat_err, 0);
    tick();
    pulse_done();
    @(negedge aclk);
    chk("t5_err_set", stat_err, 1);
    chk("t5_outst_stay0", stat_outstanding, 0);
    chk("t5_pkts", stat_pkts, 5);
    tick();

    // Reset after two beats of a chunk discards it.
    auto_done = 1'b1;
    cfg_vaddr = 48'h6000;
    base = dq_a.size();
    send_beats(2, 1'b0, '1, 32'h600);
    areset = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    chk("t6_req_valid", wr_req_valid, 0);
    chk("t6_req_vaddr", wr_req_vaddr, 0);
    chk("t6_req_len", wr_req_len, 0);
    chk("t6_s_tready", s_axis_tready, 0);
    chk("t6_m_tvalid", m_axis_tvalid, 0);
    chk("t6_err", stat_err, 0);
    chk("t6_pkts", stat_pkts, 0);
    chk("t6_outst", stat_outstanding, 0);
    tick();
    s_axis_tvalid = 1'b0;
    areset = 1'b0;
    repeat (3) tick();
    chk("t6_no_desc", dq_a.size(), base);
    cfg_vaddr = 48'h7000;
    cfg_pid   = 6'd3;
    send_beats(1, 1'b1, '1, 32'h700);
    wait_desc(base + 1);
    repeat (4) tick();
    chk("t6_ndesc", dq_a.size(), base + 1);
    chk_desc(base, 48'h7000, 64, 1'b1, 6'd3);
    chk("t6_pkts_after", stat_pkts, 1);

    // Every accepted beat must appear unchanged downstream.
    chk("nbeats", got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("beat%0d_data", i), got_d[i], exp_d[i]);
      chk($sformatf("beat%0d_keep", i), got_k[i], exp_k[i]);
      chk($sformatf("beat%0d_last", i), got_l[i], exp_l[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
